// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline write-back vs. one long-latency producer.
// Optional performance counters are built when WB_ARB_PERF_EN is defined.
module wb_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p_valid,
  input  logic [4:0]  p_rd,
  input  logic [31:0] p_data,
  output logic        p_stall,
  input  logic        l_valid,
  input  logic [4:0]  l_rd,
  input  logic [31:0] l_data,
  output logic        l_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
`ifdef WB_ARB_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [15:0] perf_force_cnt
`endif
);

  typedef enum logic {
    PIPE_PRIO = 1'b0,
    LONG_PRIO = 1'b1
  } state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;

  logic        waw_hit;
  logic        grant_p, grant_l;

  // The long-latency result is older, so a same-register collision must let it write first.
  assign waw_hit = p_valid & l_valid & (p_rd == l_rd) & (p_rd != 5'd0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PIPE_PRIO;
      wait_cnt_q <= 4'd0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    state_d    = state_q;
    wait_cnt_d = 4'd0;
    if (l_valid && !grant_l) begin
      wait_cnt_d = (wait_cnt_q == LIMIT) ? LIMIT : wait_cnt_q + 4'd1;
    end
    case (state_q)
      PIPE_PRIO: if (wait_cnt_d == LIMIT) state_d = LONG_PRIO;
      LONG_PRIO: if (!l_valid || grant_l) state_d = PIPE_PRIO;
    endcase
  end

  // Output logic: grants for the current priority state
  always_comb begin
    grant_p = 1'b0;
    grant_l = 1'b0;
    case (state_q)
      PIPE_PRIO: begin
        grant_p = p_valid & ~waw_hit;
        grant_l = l_valid & ~grant_p;
      end
      LONG_PRIO: begin
        grant_l = l_valid;
        grant_p = p_valid & ~l_valid;
      end
    endcase
  end

  assign p_stall = p_valid & ~grant_p;
  assign l_ready = grant_l;

  // Write register: address and data hold when nobody wins.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (grant_l) begin
      rf_we_d    = (l_rd != 5'd0);
      rf_waddr_d = l_rd;
      rf_wdata_d = l_data;
    end else if (grant_p) begin
      rf_we_d    = (p_rd != 5'd0);
      rf_waddr_d = p_rd;
      rf_wdata_d = p_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= 32'd0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

`ifdef WB_ARB_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [15:0] force_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
      force_cnt_q <= 16'd0;
    end else begin
      if (p_stall) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (state_q == PIPE_PRIO && state_d == LONG_PRIO) force_cnt_q <= force_cnt_q + 16'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_force_cnt = force_cnt_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed testbench for wb_port_arbiter with hand-computed expected values.
// Build with WB_ARB_PERF_EN defined to also exercise the performance counters.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p_valid;
  logic [4:0]  p_rd;
  logic [31:0] p_data;
  logic        p_stall;
  logic        l_valid;
  logic [4:0]  l_rd;
  logic [31:0] l_data;
  logic        l_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
`ifdef WB_ARB_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [15:0] perf_force_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .p_valid  (p_valid),
    .p_rd     (p_rd),
    .p_data   (p_data),
    .p_stall  (p_stall),
    .l_valid  (l_valid),
    .l_rd     (l_rd),
    .l_data   (l_data),
    .l_ready  (l_ready),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata)
`ifdef WB_ARB_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_force_cnt (perf_force_cnt)
`endif
  );

  // Inputs are driven 1 time unit after a rising edge; outputs are sampled 1 unit later.
  task automatic drive(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    p_valid = pv; p_rd = prd; p_data = pd;
    l_valid = lv; l_rd = lrd; l_data = ld;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_rf: got we=%b addr=%0d data=%h, want we=0 addr=0 data=0", rf_we, rf_waddr, rf_wdata);
    end
    rst_n = 1'b1;
    next_cycle();
    vectors++;
    if (p_stall !== 1'b0 || l_ready !== 1'b0 || rf_we !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: got p_stall=%b l_ready=%b rf_we=%b, want 0 0 0", p_stall, l_ready, rf_we);
    end
  endtask

  task automatic test_pipe_only();
    drive(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'd0);
    #1;
    vectors++;
    if (p_stall !== 1'b0 || l_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL pipe_only_grant: got p_stall=%b l_ready=%b, want 0 0", p_stall, l_ready);
    end
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    vectors++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h11) begin
      miscompares++;
      $display("FAIL pipe_only_write: got we=%b addr=%0d data=%h, want we=1 addr=5 data=11", rf_we, rf_waddr, rf_wdata);
    end
    next_cycle();
    vectors++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 32'h11) begin
      miscompares++;
      $display("FAIL pipe_only_hold: got we=%b addr=%0d data=%h, want we=0 addr=5 data=11", rf_we, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_simultaneous();
    drive(1'b1, 5'd3, 32'hA, 1'b1, 5'd7, 32'hB);
    #1;
    vectors++;
    if (p_stall !== 1'b0 || l_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL simul_c0: got p_stall=%b l_ready=%b, want 0 0", p_stall, l_ready);
    end
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hB);
    #1;
    vectors++;
    if (l_ready !== 1'b1 || rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'hA) begin
      miscompares++;
      $display("FAIL simul_c1: got l_ready=%b we=%b addr=%0d data=%h, want l_ready=1 we=1 addr=3 data=a",
               l_ready, rf_we, rf_waddr, rf_wdata);
    end
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    vectors++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hB) begin
      miscompares++;
      $display("FAIL simul_c2: got we=%b addr=%0d data=%h, want we=1 addr=7 data=b", rf_we, rf_waddr, rf_wdata);
    end
    next_cycle();
  endtask

  task automatic test_waw();
    drive(1'b1, 5'd9, 32'h1, 1'b1, 5'd9, 32'h2);
    #1;
    vectors++;
    if (l_ready !== 1'b1 || p_stall !== 1'b1) begin
      miscompares++;
      $display("FAIL waw_c0: got l_ready=%b p_stall=%b, want 1 1", l_ready, p_stall);
    end
    next_cycle();
    drive(1'b1, 5'd9, 32'h1, 1'b0, 5'd0, 32'd0);
    #1;
    vectors++;
    if (p_stall !== 1'b0 || rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h2) begin
      miscompares++;
      $display("FAIL waw_c1: got p_stall=%b we=%b addr=%0d data=%h, want p_stall=0 we=1 addr=9 data=2",
               p_stall, rf_we, rf_waddr, rf_wdata);
    end
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    vectors++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h1) begin
      miscompares++;
      $display("FAIL waw_c2: got we=%b addr=%0d data=%h, want we=1 addr=9 data=1", rf_we, rf_waddr, rf_wdata);
    end
    next_cycle();
  endtask

  task automatic test_starvation();
    // Cycles 0-3: pipeline wins with rd 1..4, long-latency request for x20 refused.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'(i + 1), 32'h100 + 32'(i), 1'b1, 5'd20, 32'hCC);
      #1;
      vectors++;
      if (l_ready !== 1'b0 || p_stall !== 1'b0) begin
        miscompares++;
        $display("FAIL starve_refuse_c%0d: got l_ready=%b p_stall=%b, want 0 0", i, l_ready, p_stall);
      end
      next_cycle();
    end
    // Cycle 4: forced long-latency win, pipeline stalls.
    drive(1'b1, 5'd10, 32'h200, 1'b1, 5'd20, 32'hCC);
    #1;
    vectors++;
    if (l_ready !== 1'b1 || p_stall !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'h103) begin
      miscompares++;
      $display("FAIL starve_force: got l_ready=%b p_stall=%b addr=%0d data=%h, want 1 1 addr=4 data=103",
               l_ready, p_stall, rf_waddr, rf_wdata);
    end
    next_cycle();
    // Cycle 5: pipeline priority again even with a fresh long-latency request.
    drive(1'b1, 5'd10, 32'h200, 1'b1, 5'd21, 32'hDD);
    #1;
    vectors++;
    if (l_ready !== 1'b0 || p_stall !== 1'b0 || rf_we !== 1'b1 || rf_waddr !== 5'd20 || rf_wdata !== 32'hCC) begin
      miscompares++;
      $display("FAIL starve_back: got l_ready=%b p_stall=%b we=%b addr=%0d data=%h, want 0 0 1 addr=20 data=cc",
               l_ready, p_stall, rf_we, rf_waddr, rf_wdata);
    end
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    vectors++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd10 || rf_wdata !== 32'h200) begin
      miscompares++;
      $display("FAIL starve_pipe_write: got we=%b addr=%0d data=%h, want we=1 addr=10 data=200", rf_we, rf_waddr, rf_wdata);
    end
    next_cycle();
  endtask

  task automatic test_x0();
    drive(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0);
    #1;
    vectors++;
    if (p_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL x0_pipe_grant: got p_stall=%b, want 0", p_stall);
    end
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55);
    #1;
    vectors++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'hFFFF || l_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL x0_pipe_write: got we=%b addr=%0d data=%h l_ready=%b, want we=0 addr=0 data=ffff l_ready=1",
               rf_we, rf_waddr, rf_wdata, l_ready);
    end
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    vectors++;
    if (rf_we !== 1'b0 || rf_wdata !== 32'h55) begin
      miscompares++;
      $display("FAIL x0_long_write: got we=%b data=%h, want we=0 data=55", rf_we, rf_wdata);
    end
    next_cycle();
  endtask

  task automatic test_async_reset();
    // Three refused cycles bring wait_cnt to 3 while pipeline writes land.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(i + 1), 32'h300 + 32'(i), 1'b1, 5'd25, 32'hEE);
      next_cycle();
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
      miscompares++;
      $display("FAIL async_reset_rf: got we=%b addr=%0d data=%h, want 0 0 0", rf_we, rf_waddr, rf_wdata);
    end
`ifdef WB_ARB_PERF_EN
    vectors++;
    if (perf_stall_cnt !== 32'd0 || perf_force_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL async_reset_perf: got stall=%0d force=%0d, want 0 0", perf_stall_cnt, perf_force_cnt);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    // A cleared wait_cnt means a full four refused cycles before the forced win.
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (l_ready !== (i == 4) || p_stall !== (i == 4)) begin
        miscompares++;
        $display("FAIL async_reset_starve_c%0d: got l_ready=%b p_stall=%b, want %b %b",
                 i, l_ready, p_stall, (i == 4), (i == 4));
      end
`ifdef WB_ARB_PERF_EN
      if (i == 4) begin
        vectors++;
        if (perf_force_cnt !== 16'd1 || perf_stall_cnt !== 32'd0) begin
          miscompares++;
          $display("FAIL perf_counts: got stall=%0d force=%0d, want 0 1", perf_stall_cnt, perf_force_cnt);
        end
      end
`endif
      if (i < 4) begin
        @(posedge clk);
        #1;
        drive(1'b1, 5'(i + 5), 32'h400 + 32'(i), 1'b1, 5'd25, 32'hEE);
        #1;
      end
    end
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    vectors++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd25 || rf_wdata !== 32'hEE) begin
      miscompares++;
      $display("FAIL async_reset_long_write: got we=%b addr=%0d data=%h, want we=1 addr=25 data=ee",
               rf_we, rf_waddr, rf_wdata);
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_pipe_only();
    test_simultaneous();
    test_waw();
    test_starvation();
    test_x0();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
